// File: rtl/dht22_bcd_conv.sv
// DHT22 frame checker and sequential double-dabble BCD converter for humidity and signed temperature.
// Optional error counter output enabled with `define DHT22_ERR_CNT_EN.
//   state  | meaning
//   IDLE   | waiting for frame_valid
//   CHECK  | checksum compare, converter load with saturated humidity
//   CONV_H | BIN_W shift/add-3 steps on humidity
//   CONV_T | BIN_W shift/add-3 steps on temperature magnitude
//   DONE   | publish shadow results, pulse data_ready
module dht22_bcd_conv #(
  parameter int BIN_W   = 16,
  parameter int SAT_VAL = 999
) (
  input  logic            clk,
  input  logic            arstn,
  input  logic            frame_valid,
  input  logic [39:0]     frame,
  output logic            busy,
  output logic [2:0][3:0] humidity_bcd,
  output logic [2:0][3:0] temperature_bcd,
  output logic            negativo_temp,
  output logic            data_ready,
  output logic            crc_err
`ifdef DHT22_ERR_CNT_EN
  ,
  output logic [7:0]      err_count
`endif
);

  localparam int CW = $clog2(BIN_W);
  localparam logic [BIN_W-1:0] SAT = BIN_W'(SAT_VAL);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BIN_W - 1);

  typedef enum logic [2:0] {IDLE, CHECK, CONV_H, CONV_T, DONE} state_t;

  state_t r_state, w_state_nx;

  logic [39:0]      r_frame;
  logic [11:0]      r_bcd;
  logic [BIN_W-1:0] r_bin;
  logic [CW-1:0]    r_cnt;
  logic [2:0][3:0]  r_hum_res, r_tmp_res, r_hum_bcd, r_tmp_bcd;
  logic             r_neg_res, r_neg;
  logic             r_data_ready, r_crc_err;

  logic [15:0]      w_hum, w_temp;
  logic [7:0]       w_chk, w_sum8;
  logic             w_crc_ok, w_neg, w_cnt_tc;
  logic [BIN_W-1:0] w_hum_in, w_tmag_in, w_hum_sat, w_tmag_sat;
  logic [11:0]      w_adj, w_bcd_nx;
  logic [BIN_W-1:0] w_bin_nx;
  logic             w_accept, w_crc_fail, w_drop;

  assign w_hum      = r_frame[39:24];
  assign w_temp     = r_frame[23:8];
  assign w_chk      = r_frame[7:0];
  assign w_sum8     = w_hum[15:8] + w_hum[7:0] + w_temp[15:8] + w_temp[7:0];
  assign w_crc_ok   = (w_sum8 == w_chk);
  assign w_neg      = w_temp[15] & (w_temp[14:0] != 15'd0);
  assign w_hum_in   = BIN_W'(w_hum);
  assign w_tmag_in  = BIN_W'({1'b0, w_temp[14:0]});
  assign w_hum_sat  = (w_hum_in > SAT) ? SAT : w_hum_in;
  assign w_tmag_sat = (w_tmag_in > SAT) ? SAT : w_tmag_in;
  assign w_cnt_tc   = (r_cnt == '0);

  // One double-dabble step: add 3 to nibbles >= 5, then shift the whole {bcd, bin} left.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_nx = {w_adj[10:0], r_bin[BIN_W-1]};
    w_bin_nx = {r_bin[BIN_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nx = CHECK;
      CHECK:   w_state_nx = w_crc_ok ? CONV_H : IDLE;
      CONV_H:  if (w_cnt_tc) w_state_nx = CONV_T;
      CONV_T:  if (w_cnt_tc) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // New frames wait until the completion pulse has gone low.
  always_comb begin
    busy       = (r_state != IDLE);
    w_accept   = (r_state == IDLE) & frame_valid & ~r_data_ready & ~r_crc_err;
    w_crc_fail = (r_state == CHECK) & ~w_crc_ok;
    w_drop     = (r_state != IDLE) & frame_valid;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_frame      <= '0;
      r_bcd        <= '0;
      r_bin        <= '0;
      r_cnt        <= '0;
      r_hum_res    <= '0;
      r_tmp_res    <= '0;
      r_neg_res    <= 1'b0;
      r_hum_bcd    <= '0;
      r_tmp_bcd    <= '0;
      r_neg        <= 1'b0;
      r_data_ready <= 1'b0;
      r_crc_err    <= 1'b0;
    end else begin
      r_data_ready <= 1'b0;
      r_crc_err    <= 1'b0;
      if (w_accept) r_frame <= frame;
      case (r_state)
        CHECK: begin
          r_bcd     <= '0;
          r_bin     <= w_hum_sat;
          r_cnt     <= CNT_LOAD;
          r_crc_err <= ~w_crc_ok;
        end
        CONV_H: begin
          if (w_cnt_tc) begin
            r_hum_res <= w_bcd_nx;
            r_neg_res <= w_neg;
            r_bcd     <= '0;
            r_bin     <= w_tmag_sat;
            r_cnt     <= CNT_LOAD;
          end else begin
            r_bcd <= w_bcd_nx;
            r_bin <= w_bin_nx;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        CONV_T: begin
          r_bcd <= w_bcd_nx;
          r_bin <= w_bin_nx;
          r_cnt <= r_cnt - 1'b1;
          if (w_cnt_tc) r_tmp_res <= w_bcd_nx;
        end
        DONE: begin
          r_hum_bcd    <= r_hum_res;
          r_tmp_bcd    <= r_tmp_res;
          r_neg        <= r_neg_res;
          r_data_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign humidity_bcd    = r_hum_bcd;
  assign temperature_bcd = r_tmp_bcd;
  assign negativo_temp   = r_neg;
  assign data_ready      = r_data_ready;
  assign crc_err         = r_crc_err;

`ifdef DHT22_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  logic [8:0] w_err_sum;

  assign w_err_sum = {1'b0, r_err_cnt} + {8'd0, w_crc_fail} + {8'd0, w_drop};

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)                r_err_cnt <= '0;
    else if (w_err_sum[8])     r_err_cnt <= 8'hFF;
    else                       r_err_cnt <= w_err_sum[7:0];
  end

  assign err_count = r_err_cnt;
`endif

endmodule
